ysyx_24110015_pcu: RTL

Program-counter unit: the stage directly upstream of instruction fetch in the ysyx_24110015 core. It owns the architectural PC and offers it to fetch over a valid/ready handshake. After fetch accepts a PC, the unit waits for the commit report from writeback, then computes the next PC and issues it. The next PC is either sequential or a redirect for a branch, jump, trap or mret. It also keeps the cycle and retired-instruction counters used by the CSR unit.

---
 rtl/ysyx_24110015_pkg.sv | 18 +
 rtl/ysyx_24110015_csr_cnt64.sv | 30 +++
 rtl/ysyx_24110015_pcu.sv | 114 +++++++++++
 3 files changed

// File: rtl/ysyx_24110015_pkg.sv
// ysyx_24110015_pkg
// Shared definitions for the ysyx_24110015 core:
//   pcu_state_e       - program-counter unit state encoding (2 bits)
//   RESET_PC_DEFAULT  - first PC issued after reset
//   INST_BYTES        - size of one instruction, the sequential PC step
package ysyx_24110015_pkg;

  typedef enum logic [1:0] {
    PCU_ISSUE = 2'd0,
    PCU_WAIT  = 2'd1,
    PCU_HALT  = 2'd2,
    PCU_ERR   = 2'd3
  } pcu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int          INST_BYTES       = 4;

endpackage

// File: rtl/ysyx_24110015_csr_cnt64.sv
// ysyx_24110015_csr_cnt64
// 64-bit free-running counter used for mcycle / minstret. Wraps at 2^64.
// Ports:
//   clk    clock
//   clr_i  synchronous clear, has priority over en_i
//   en_i   increment by one on this edge
//   cnt_o  current count
module ysyx_24110015_csr_cnt64 (
  input  logic        clk,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_24110015_pcu.sv
// ysyx_24110015_pcu
// Program-counter unit. Owns the architectural PC, offers it to fetch and
// waits for the commit report before computing the next PC (one instruction
// in flight). Also keeps the mcycle / minstret counters.
// Handshake: fetch takes the PC on a rising edge where pc_valid && pc_ready;
// while pc_valid is high pc is held stable; pc_valid never drops without a
// handshake except on reset. cm_* are only looked at when cm_valid is high.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_valid/pc_ready   PC offer to fetch; pc is the offered PC
//   cm_valid            commit of the in-flight instruction
//   cm_redirect/target  next PC is cm_target instead of pc+4
//   cm_halt             committed instruction was ebreak, stop issuing
//   halted, err         unit is in HALT / ERR (err is sticky until reset)
//   mcycle, minstret    cycle and retired-instruction counters
//   dbg_state           current FSM state for observation
module ysyx_24110015_pcu
  import ysyx_24110015_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            pc_valid,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc,
  input  logic            cm_valid,
  input  logic            cm_redirect,
  input  logic [XLEN-1:0] cm_target,
  input  logic            cm_halt,
  output logic            halted,
  output logic            err,
  output logic [63:0]     mcycle,
  output logic [63:0]     minstret,
  output logic [1:0]      dbg_state
);

  pcu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            retire;
  logic            misaligned;

  // Only meaningful for a redirecting commit; halt wins over redirect.
  assign misaligned = cm_redirect && (cm_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    unique case (state_q)
      PCU_ISSUE: begin
        // A commit with nothing in flight is a protocol error, and it
        // takes precedence over a same-cycle handshake.
        if (cm_valid)      state_d = PCU_ERR;
        else if (pc_ready) state_d = PCU_WAIT;
      end
      PCU_WAIT: begin
        if (cm_valid) begin
          if (cm_halt) begin
            state_d = PCU_HALT;
            retire  = 1'b1;
          end else if (misaligned) begin
            state_d = PCU_ERR;
          end else begin
            pc_d    = cm_redirect ? cm_target : pc_q + XLEN'(INST_BYTES);
            state_d = PCU_ISSUE;
            retire  = 1'b1;
          end
        end
      end
      PCU_HALT: begin
        if (cm_valid) state_d = PCU_ERR;
      end
      PCU_ERR: begin
        state_d = PCU_ERR;
      end
      default: state_d = PCU_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PCU_ISSUE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs come from registers only; rst merely masks the offer so fetch
  // never sees a PC while reset is held.
  assign pc_valid  = (state_q == PCU_ISSUE) && !rst;
  assign pc        = pc_q;
  assign halted    = (state_q == PCU_HALT);
  assign err       = (state_q == PCU_ERR);
  assign dbg_state = state_q;

  ysyx_24110015_csr_cnt64 u_mcycle (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (1'b1),
    .cnt_o (mcycle)
  );

  ysyx_24110015_csr_cnt64 u_minstret (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (retire),
    .cnt_o (minstret)
  );

endmodule
